// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: next-PC select codes, RV32I
// control-flow opcodes, FSM state encoding and next-PC arithmetic helpers.
package pc_seq_pkg;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JAL    = 2'b10;
  localparam logic [1:0] NPC_JALR   = 2'b11;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Select code from the opcode field; a branch only redirects when taken.
  function automatic logic [1:0] npc_decode(input logic [31:0] inst, input logic taken);
    logic [1:0] op;
    op = NPC_PLUS4;
    case (inst[6:0])
      OP_BRANCH: op = taken ? NPC_BRANCH : NPC_PLUS4;
      OP_JAL:    op = NPC_JAL;
      OP_JALR:   op = NPC_JALR;
      default:   op = NPC_PLUS4;
    endcase
    return op;
  endfunction

  // Next PC for a given select code; all sums wrap modulo 2^32.
  function automatic logic [31:0] npc_next(input logic [1:0] op, input logic [31:0] pc,
                                           input logic [31:0] inst, input logic [31:0] aluout);
    logic [31:0] b_imm;
    logic [31:0] j_imm;
    logic [31:0] result;
    b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    case (op)
      NPC_BRANCH: result = pc + b_imm;
      NPC_JAL:    result = pc + j_imm;
      NPC_JALR:   result = aluout & 32'hFFFF_FFFE;
      default:    result = pc + 32'd4;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/pc_seq_timer.sv
// Fetch timeout counter: counts enabled cycles from zero and flags the cycle
// in which the TIMEOUT-th consecutive enabled cycle occurs.
module pc_seq_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] count_reg;

  assign expired = enable && (count_reg == TW'(TIMEOUT - 1));

  // Count waiting cycles; restart whenever the sequencer leaves FETCH.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + TW'(1);
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle PC sequencer: IDLE -> FETCH -> EXEC -> COMMIT -> FETCH, with
// an absorbing HALT on fetch timeout or misaligned commit target.
// Optional trap redirect is built when the macro PC_TRAP_EN is defined.
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      inst,
  output logic             inst_valid,
  input  logic             ex_done,
  input  logic             branch_taken,
  input  logic [31:0]      aluout,
  output logic [1:0]       npc_op,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] retired,
  output logic             fetch_err,
`ifdef PC_TRAP_EN
  input  logic             trap_req,
  output logic [31:0]      epc,
`endif
  output logic             align_err
);

  // A misaligned trap vector would halt the core on every trap.
  if (TRAP_VEC[1:0] != 2'b00) begin : g_trap_vec_check
    $error("pc_seq_ctrl: TRAP_VEC must be word-aligned");
  end

  state_t      state_reg;
  state_t      state_next;
  logic [1:0]  op_reg;
  logic [31:0] alu_reg;
  logic [1:0]  npc_dec;
  logic [31:0] next_pc;
  logic        tmr_expired;
  logic        load_inst;
  logic        ex_accept;
  logic        commit_ok;
  logic        commit_bad;
  logic        timeout_hit;
  logic        take_trap;

  assign npc_dec    = npc_decode(inst, branch_taken);
  assign next_pc    = npc_next(op_reg, pc, inst, alu_reg);
  assign imem_req   = (state_reg == ST_FETCH);
  assign imem_addr  = pc;
  assign inst_valid = (state_reg == ST_EXEC);
  // Live decode while executing; the captured select is shown afterwards.
  assign npc_op     = (state_reg == ST_EXEC) ? npc_dec : op_reg;

  pc_seq_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_reg != ST_FETCH),
    .enable ((state_reg == ST_FETCH) && !imem_ack),
    .expired(tmr_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and one-cycle datapath strobes.
  always_comb begin
    state_next  = state_reg;
    load_inst   = 1'b0;
    ex_accept   = 1'b0;
    commit_ok   = 1'b0;
    commit_bad  = 1'b0;
    timeout_hit = 1'b0;
    take_trap   = 1'b0;
    case (state_reg)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          load_inst  = 1'b1;
          state_next = ST_EXEC;
        end else if (tmr_expired) begin
          timeout_hit = 1'b1;
          state_next  = ST_HALT;
        end
      end
      ST_EXEC: begin
`ifdef PC_TRAP_EN
        if (trap_req) begin
          take_trap  = 1'b1;
          state_next = ST_FETCH;
        end else
`endif
        if (ex_done) begin
          ex_accept  = 1'b1;
          state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (next_pc[1:0] != 2'b00) begin
          commit_bad = 1'b1;
          state_next = ST_HALT;
        end else begin
          commit_ok  = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  // Architectural PC, instruction latch, retire counter and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      inst      <= '0;
      retired   <= '0;
      fetch_err <= 1'b0;
      align_err <= 1'b0;
      op_reg    <= NPC_PLUS4;
      alu_reg   <= '0;
`ifdef PC_TRAP_EN
      epc       <= '0;
`endif
    end else begin
      if (load_inst) begin
        inst <= imem_rdata;
      end
      // Capture select and JALR source so COMMIT is immune to input changes.
      if (ex_accept) begin
        op_reg  <= npc_dec;
        alu_reg <= aluout;
      end
      if (commit_ok) begin
        pc      <= next_pc;
        retired <= retired + CNT_W'(1);
      end
      if (commit_bad) begin
        align_err <= 1'b1;
      end
      if (timeout_hit) begin
        fetch_err <= 1'b1;
      end
`ifdef PC_TRAP_EN
      if (take_trap) begin
        epc <= pc;
        pc  <= TRAP_VEC;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: expected fetch address, select code, next
// PC and retire count are queued per instruction and compared as the DUT
// reaches each stage. Define PC_TRAP_EN to exercise the trap path.
module tb_pc_seq_ctrl;

  localparam logic [31:0] ADDI   = 32'h0010_0093;  // addi x1, x0, 1
  localparam logic [31:0] JALR   = 32'h0000_8067;  // jalr x0, 0(x1)
  localparam logic [31:0] BEQ8   = 32'h0000_0463;  // beq x0, x0, +8
  localparam logic [31:0] JALM16 = 32'hFF1F_F06F;  // jal x0, -16

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        ex_done;
  logic        branch_taken;
  logic [31:0] aluout;
  logic [1:0]  npc_op;
  logic [31:0] pc;
  logic [2:0]  retired;
  logic        fetch_err;
  logic        align_err;
`ifdef PC_TRAP_EN
  logic        trap_req;
  logic [31:0] epc;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  op;
    logic [31:0] npc;
    logic [2:0]  ret;
    bit          bad;
    bit          trap;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] ret_model;

  always #5 clk = ~clk;

  pc_seq_ctrl #(
    .RESET_PC(32'h0000_0000),
    .TRAP_VEC(32'h0000_0100),
    .TIMEOUT (16),
    .CNT_W   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .ex_done     (ex_done),
    .branch_taken(branch_taken),
    .aluout      (aluout),
    .npc_op      (npc_op),
    .pc          (pc),
    .retired     (retired),
    .fetch_err   (fetch_err),
`ifdef PC_TRAP_EN
    .trap_req    (trap_req),
    .epc         (epc),
`endif
    .align_err   (align_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One instruction: fetch with lat wait cycles, execute, then commit or trap.
  task automatic run_instr(input logic [31:0] ins, input logic taken, input logic [31:0] alu,
                           input logic [1:0] op, input logic [31:0] npc, input int lat,
                           input bit bad, input bit trap, input logic [31:0] cur_pc);
    exp_t e;
    exp_t got_e;
    int   n;
    e.addr = cur_pc;
    e.op   = op;
    e.npc  = bad ? cur_pc : (trap ? 32'h0000_0100 : npc);
    e.ret  = (bad || trap) ? ret_model : ret_model + 3'd1;
    e.bad  = bad;
    e.trap = trap;
    sb.push_back(e);
    ret_model = e.ret;

    n = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'b0, imem_req}, 32'd1);
    got_e = sb.pop_front();
    chk("imem_addr", imem_addr, got_e.addr);
    repeat (lat) @(negedge clk);
    chk("req_held", {31'b0, imem_req}, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("inst", inst, ins);
    branch_taken = taken;
    aluout       = alu;
`ifdef PC_TRAP_EN
    trap_req     = trap;
`endif
    ex_done      = 1'b1;
    #1;
    chk("npc_op", {30'b0, npc_op}, {30'b0, got_e.op});
    @(negedge clk);
    ex_done      = 1'b0;
    branch_taken = 1'b0;
    aluout       = 32'h0;
`ifdef PC_TRAP_EN
    trap_req     = 1'b0;
    if (got_e.trap) begin
      chk("trap_pc", pc, got_e.npc);
      chk("epc", epc, got_e.addr);
      chk("trap_retired", {29'b0, retired}, {29'b0, got_e.ret});
      return;
    end
`endif
    chk("commit_no_valid", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    chk("pc", pc, got_e.npc);
    chk("retired", {29'b0, retired}, {29'b0, got_e.ret});
    chk("align_err", {31'b0, align_err}, {31'b0, got_e.bad});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ret_model = 3'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    imem_ack     = 1'b0;
    imem_rdata   = 32'h0;
    ex_done      = 1'b0;
    branch_taken = 1'b0;
    aluout       = 32'h0;
`ifdef PC_TRAP_EN
    trap_req     = 1'b0;
`endif
    ret_model    = 3'd0;
    repeat (3) @(negedge clk);

    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_retired", {29'b0, retired}, 32'd0);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_align_err", {31'b0, align_err}, 32'd0);
`ifdef PC_TRAP_EN
    chk("rst_epc", epc, 32'h0);
`endif
    rst = 1'b0;

    // Sequential addi stream with varied imem latency.
    run_instr(ADDI, 1'b0, 32'h0, 2'b00, 32'h4, 1, 1'b0, 1'b0, 32'h0);
    run_instr(ADDI, 1'b0, 32'h0, 2'b00, 32'h8, 0, 1'b0, 1'b0, 32'h4);
    run_instr(ADDI, 1'b0, 32'h0, 2'b00, 32'hC, 2, 1'b0, 1'b0, 32'h8);
    chk("retired_three", {29'b0, retired}, 32'd3);

    // Branch taken / not taken from pc=0x10.
    run_instr(JALR, 1'b0, 32'h10, 2'b11, 32'h10, 1, 1'b0, 1'b0, 32'hC);
    run_instr(BEQ8, 1'b1, 32'h0, 2'b01, 32'h18, 1, 1'b0, 1'b0, 32'h10);
    run_instr(JALR, 1'b0, 32'h10, 2'b11, 32'h10, 1, 1'b0, 1'b0, 32'h18);
    run_instr(BEQ8, 1'b0, 32'h0, 2'b00, 32'h14, 1, 1'b0, 1'b0, 32'h10);

    // Counter wraps 7 -> 0 on this commit.
    run_instr(JALR, 1'b0, 32'h20, 2'b11, 32'h20, 1, 1'b0, 1'b0, 32'h14);
    chk("retired_wrap", {29'b0, retired}, 32'd0);

    // Backward JAL, PC wrap past 2^32, JALR aligned and misaligned.
    run_instr(JALM16, 1'b0, 32'h0, 2'b10, 32'h10, 1, 1'b0, 1'b0, 32'h20);
    run_instr(JALR, 1'b0, 32'hFFFF_FFFC, 2'b11, 32'hFFFF_FFFC, 1, 1'b0, 1'b0, 32'h10);
    run_instr(ADDI, 1'b0, 32'h0, 2'b00, 32'h0, 1, 1'b0, 1'b0, 32'hFFFF_FFFC);
    run_instr(JALR, 1'b0, 32'h105, 2'b11, 32'h104, 1, 1'b0, 1'b0, 32'h0);
    run_instr(JALR, 1'b0, 32'h103, 2'b11, 32'h0, 1, 1'b1, 1'b0, 32'h104);

    // HALT absorbs stray acks and ex_done.
    repeat (3) @(negedge clk);
    imem_ack = 1'b1;
    ex_done  = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    ex_done  = 1'b0;
    @(negedge clk);
    chk("halt_req", {31'b0, imem_req}, 32'd0);
    chk("halt_valid", {31'b0, inst_valid}, 32'd0);
    chk("halt_pc", pc, 32'h104);
    chk("halt_align_err", {31'b0, align_err}, 32'd1);
    chk("halt_retired", {29'b0, retired}, 32'd4);

    // Fetch timeout: 16 cycles without ack.
    do_reset();
    @(negedge clk);
    chk("to_req_start", {31'b0, imem_req}, 32'd1);
    repeat (15) @(negedge clk);
    chk("to_req_15", {31'b0, imem_req}, 32'd1);
    chk("to_err_15", {31'b0, fetch_err}, 32'd0);
    @(negedge clk);
    chk("to_err_16", {31'b0, fetch_err}, 32'd1);
    chk("to_req_16", {31'b0, imem_req}, 32'd0);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    chk("to_halt_valid", {31'b0, inst_valid}, 32'd0);
    chk("to_halt_req", {31'b0, imem_req}, 32'd0);
    chk("to_halt_err", {31'b0, fetch_err}, 32'd1);

    // Reset while a fetch is outstanding.
    do_reset();
    chk("after_rst_err", {31'b0, fetch_err}, 32'd0);
    run_instr(ADDI, 1'b0, 32'h0, 2'b00, 32'h4, 1, 1'b0, 1'b0, 32'h0);
    chk("midfetch_req", {31'b0, imem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_retired", {29'b0, retired}, 32'd0);
    rst = 1'b0;
    ret_model = 3'd0;

`ifdef PC_TRAP_EN
    // Trap with ex_done in the same cycle at pc=0x40.
    run_instr(JALR, 1'b0, 32'h40, 2'b11, 32'h40, 1, 1'b0, 1'b0, 32'h0);
    run_instr(ADDI, 1'b0, 32'h0, 2'b00, 32'h0, 1, 1'b0, 1'b1, 32'h40);
    run_instr(ADDI, 1'b0, 32'h0, 2'b00, 32'h104, 0, 1'b0, 1'b0, 32'h100);
`else
    run_instr(ADDI, 1'b0, 32'h0, 2'b00, 32'h4, 1, 1'b0, 1'b0, 32'h0);
`endif

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
